// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: two-master round-robin Wishbone arbiter with stall watchdog and sticky timeout irq
module periph_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic [DW-1:0] m0_dat_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [DW-1:0] m1_dat_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic          s_ack_i,
  input  logic [DW-1:0] s_dat_i,
  output logic [1:0]    grant_o,
  input  logic          irq_clr_i,
  output logic          timeout_irq_o
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ERR} state_e;
  localparam logic [15:0] TO_M1 = 16'(TIMEOUT - 1);
  state_e state_q, state_d;
  logic last_q, last_d, irq_q, irq_d;
  logic [15:0] cnt_q, cnt_d;
  logic req0, req1, own, sel1, cyc_x, stb_x;
  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  assign own = (state_q == OWN0) | (state_q == OWN1);
  assign sel1 = state_q == OWN1;
  assign cyc_x = sel1 ? m1_cyc_i : m0_cyc_i;
  assign stb_x = sel1 ? m1_stb_i : m0_stb_i;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    if (state_q == IDLE) begin
      if (req0 & req1) state_d = last_q ? OWN0 : OWN1;
      else if (req0) state_d = OWN0;
      else if (req1) state_d = OWN1;
    end else if (own) begin
      if (!cyc_x) begin
        state_d = IDLE;
        last_d = sel1;
      end else if (!s_ack_i && cnt_q == TO_M1) begin
        state_d = ERR;
        last_d = sel1;
      end
    end else begin
      state_d = IDLE;
    end
    cnt_d = (!own || s_ack_i) ? 16'd0 : cnt_q + 16'(stb_x);
    irq_d = (state_d == ERR) | (irq_q & ~irq_clr_i);
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      irq_q <= irq_d;
    end
  end
  // Owner's signals pass straight through; everything is zero without a grant.
  assign s_cyc_o = own & cyc_x;
  assign s_stb_o = own & stb_x;
  assign s_we_o = own & (sel1 ? m1_we_i : m0_we_i);
  assign s_sel_o = own ? (sel1 ? m1_sel_i : m0_sel_i) : '0;
  assign s_adr_o = own ? (sel1 ? m1_adr_i : m0_adr_i) : '0;
  assign s_dat_o = own ? (sel1 ? m1_dat_i : m0_dat_i) : '0;
  assign m0_ack_o = (state_q == OWN0) & s_ack_i;
  assign m1_ack_o = sel1 & s_ack_i;
  assign m0_dat_o = (state_q == OWN0) ? s_dat_i : '0;
  assign m1_dat_o = sel1 ? s_dat_i : '0;
  assign m0_err_o = (state_q == ERR) & ~last_q;
  assign m1_err_o = (state_q == ERR) & last_q;
  assign grant_o = {sel1, state_q == OWN0};
  assign timeout_irq_o = irq_q;
endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter: table-driven cycle vectors plus hand-written reset sequences
module tb_periph_bus_arbiter;
  localparam logic [31:0] A0 = 32'h3000_0004, D0 = 32'hA5A5_0001;
  localparam logic [31:0] A1 = 32'h3000_0010, D1 = 32'h1234_5678, SD = 32'hDEAD_BEEF;
  logic clk = 0, rst = 0;
  logic m0_cyc = 0, m0_stb = 0, m1_cyc = 0, m1_stb = 0, s_ack = 0, irq_clr = 0;
  logic m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we, irq;
  logic [31:0] m0_dat, m1_dat, s_adr, s_dat;
  logic [3:0] s_sel;
  logic [1:0] grant;
  int pass = 0, total = 0;
  typedef struct {
    logic c0, s0, c1, s1, ack, clr;
    logic [1:0] g;
    logic a0, a1, e0, e1, irq;
  } vec_t;
  vec_t v[$];
  periph_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(1'b1), .m0_sel_i(4'hF),
    .m0_adr_i(A0), .m0_dat_i(D0), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_dat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(1'b0), .m1_sel_i(4'h3),
    .m1_adr_i(A1), .m1_dat_i(D1), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_dat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_dat), .s_ack_i(s_ack), .s_dat_i(SD),
    .grant_o(grant), .irq_clr_i(irq_clr), .timeout_irq_o(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic check_zero(input string tag);
    check({tag, " grant"}, 32'(grant), 0);
    check({tag, " s_cyc"}, 32'(s_cyc), 0);
    check({tag, " s_stb"}, 32'(s_stb), 0);
    check({tag, " s_adr"}, s_adr, 0);
    check({tag, " s_dat"}, s_dat, 0);
    check({tag, " acks"}, {30'd0, m0_ack, m1_ack}, 0);
    check({tag, " errs"}, {30'd0, m0_err, m1_err}, 0);
    check({tag, " m0_dat"}, m0_dat, 0);
    check({tag, " m1_dat"}, m1_dat, 0);
    check({tag, " irq"}, 32'(irq), 0);
  endtask
  function automatic vec_t mk(logic c0, s0, c1, s1, ack, clr, logic [1:0] g, logic a0, a1, e0, e1, q);
    mk = '{c0, s0, c1, s1, ack, clr, g, a0, a1, e0, e1, q};
  endfunction
  initial begin
    // simultaneous single-beat contests: m0, m1, m0, m1
    for (int k = 0; k < 2; k++) begin
      v.push_back(mk(1,1,1,1,0,0,2'b00,0,0,0,0,0));
      v.push_back(mk(1,1,1,1,1,0,2'b01,1,0,0,0,0));
      v.push_back(mk(0,0,1,1,0,0,2'b01,0,0,0,0,0));
      v.push_back(mk(1,1,1,1,0,0,2'b00,0,0,0,0,0));
      v.push_back(mk(1,1,1,1,1,0,2'b10,0,1,0,0,0));
      v.push_back(mk(k==0,k==0,0,0,0,0,2'b10,0,0,0,0,0));
    end
    v.push_back(mk(0,0,0,0,0,0,2'b00,0,0,0,0,0));
    // single m0 write, slave acks two cycles after grant
    v.push_back(mk(1,1,0,0,0,0,2'b00,0,0,0,0,0));
    v.push_back(mk(1,1,0,0,0,0,2'b01,0,0,0,0,0));
    v.push_back(mk(1,1,0,0,0,0,2'b01,0,0,0,0,0));
    v.push_back(mk(1,1,0,0,1,0,2'b01,1,0,0,0,0));
    v.push_back(mk(0,0,0,0,0,0,2'b01,0,0,0,0,0));
    v.push_back(mk(0,0,0,0,0,0,2'b00,0,0,0,0,0));
    // burst lock: m1 three acked beats with a stb gap, m0 waiting
    v.push_back(mk(1,1,1,1,0,0,2'b00,0,0,0,0,0));
    v.push_back(mk(1,1,1,1,1,0,2'b10,0,1,0,0,0));
    v.push_back(mk(1,1,1,0,0,0,2'b10,0,0,0,0,0));
    v.push_back(mk(1,1,1,1,1,0,2'b10,0,1,0,0,0));
    v.push_back(mk(1,1,1,1,1,0,2'b10,0,1,0,0,0));
    v.push_back(mk(1,1,0,0,0,0,2'b10,0,0,0,0,0));
    v.push_back(mk(1,1,0,0,0,0,2'b00,0,0,0,0,0));
    v.push_back(mk(1,1,0,0,1,0,2'b01,1,0,0,0,0));
    v.push_back(mk(0,0,0,0,0,0,2'b01,0,0,0,0,0));
    v.push_back(mk(0,0,0,0,0,0,2'b00,0,0,0,0,0));
    // timeout: grant G, err at G+8, irq sticky until cleared, m1 served next
    v.push_back(mk(1,1,0,0,0,0,2'b00,0,0,0,0,0));
    for (int k = 0; k < 8; k++) v.push_back(mk(1,1,1,1,0,0,2'b01,0,0,0,0,0));
    v.push_back(mk(1,1,1,1,0,0,2'b00,0,0,1,0,1));
    v.push_back(mk(1,1,1,1,0,0,2'b00,0,0,0,0,1));
    v.push_back(mk(1,1,1,1,0,1,2'b10,0,0,0,0,1));
    v.push_back(mk(1,1,1,1,1,0,2'b10,0,1,0,0,0));
    v.push_back(mk(0,0,0,0,0,0,2'b10,0,0,0,0,0));
    v.push_back(mk(0,0,0,0,1,0,2'b00,0,0,0,0,0));
    // asynchronous reset mid-clock, inputs active, ack forced high
    m0_cyc = 1; m0_stb = 1; s_ack = 1;
    #2 rst = 1;
    #1 check_zero("reset");
    @(negedge clk);
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    rst = 0;
    #1 check("post-reset grant", 32'(grant), 0);
    foreach (v[i]) begin
      @(negedge clk);
      {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, irq_clr} = {v[i].c0, v[i].s0, v[i].c1, v[i].s1, v[i].ack, v[i].clr};
      #1;
      check($sformatf("v%0d grant", i), 32'(grant), 32'(v[i].g));
      check($sformatf("v%0d ack", i), {30'd0, m0_ack, m1_ack}, {30'd0, v[i].a0, v[i].a1});
      check($sformatf("v%0d err", i), {30'd0, m0_err, m1_err}, {30'd0, v[i].e0, v[i].e1});
      check($sformatf("v%0d irq", i), 32'(irq), 32'(v[i].irq));
      check($sformatf("v%0d s_cyc", i), 32'(s_cyc), v[i].g == 2'b01 ? 32'(v[i].c0) : v[i].g == 2'b10 ? 32'(v[i].c1) : 0);
      check($sformatf("v%0d s_adr", i), s_adr, v[i].g == 2'b01 ? A0 : v[i].g == 2'b10 ? A1 : 0);
      check($sformatf("v%0d s_dat", i), s_dat, v[i].g == 2'b01 ? D0 : v[i].g == 2'b10 ? D1 : 0);
      check($sformatf("v%0d s_we", i), 32'(s_we), 32'(v[i].g == 2'b01));
      check($sformatf("v%0d s_sel", i), 32'(s_sel), v[i].g == 2'b01 ? 32'hF : v[i].g == 2'b10 ? 32'h3 : 0);
      check($sformatf("v%0d m0_dat", i), m0_dat, v[i].g == 2'b01 ? SD : 0);
      check($sformatf("v%0d m1_dat", i), m1_dat, v[i].g == 2'b10 ? SD : 0);
    end
    // reset during OWN1 with stb pending drops everything, m0 wins next contest
    @(negedge clk);
    {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, irq_clr} = 6'b001100;
    @(negedge clk);
    #1 check("own1 grant", 32'(grant), 32'h2);
    s_ack = 1;
    #1 rst = 1;
    #1 check_zero("mid-own1 reset");
    @(negedge clk);
    rst = 0; s_ack = 0;
    {m0_cyc, m0_stb, m1_cyc, m1_stb} = 4'b1111;
    #1 check("after reset idle", 32'(grant), 0);
    @(negedge clk);
    #1 check("after reset winner", 32'(grant), 32'h1);
    {m0_cyc, m0_stb, m1_cyc, m1_stb} = 4'b0000;
    @(negedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
